// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data words, register selects, writeback select and MEM-stage states.
// word_eq compares word addresses, ignoring byte-offset bits [1:0].
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [2:0] {
    ALU = 3'd0,
    MEM = 3'd1,
    PC4 = 3'd2,
    LUI = 3'd3,
    SC  = 3'd4
  } memtoreg_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } mem_state_t;

  function automatic logic word_eq(input word_t a, input word_t b);
    return ((a ^ b) >> 2) == 32'd0;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-cache request/response bus between the MEM stage (master) and the dcache (slave).
interface mem_stage_if;
  import cpu_types_pkg::*;

  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  dhit;
  word_t dmemload;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );
endinterface

// File: rtl/mem_stage_link_reg.sv
// LL/SC link register: holds the linked word address and resolves set/clear priority.
module link_reg
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  set,
  input  word_t set_addr,
  input  logic  sc_done,
  input  logic  st_done,
  input  word_t st_addr,
  input  logic  snoop_inv,
  input  word_t snoop_addr,
  input  word_t cmp_addr,
  output logic  link_hit
);

  logic  link_valid;
  word_t link_addr;
  logic  snoop_clr;
  logic  st_clr;

  assign snoop_clr = snoop_inv & word_eq(snoop_addr, link_addr);
  assign st_clr    = st_done & word_eq(st_addr, link_addr);
  assign link_hit  = link_valid & word_eq(cmp_addr, link_addr);

  // A new link survives a concurrent snoop unless the snoop hits the word being linked.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else if (set) begin
      link_addr  <= set_addr;
      link_valid <= ~(snoop_inv & word_eq(snoop_addr, set_addr));
    end else if (sc_done || st_clr || snoop_clr) begin
      link_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: dcache request sequencing, LL/SC handling, stall generation and MEM/WB register.
//   state | meaning
//   IDLE  | requests driven straight from EX/MEM; zero-latency hits complete here
//   WAIT  | missed request replayed from captured registers until dhit
//   HALT  | halt retired; no requests, wb_halt held until reset
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter bit LLSC_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        valid_i,
  input  logic        dREN_i,
  input  logic        dWEN_i,
  input  logic        datomic_i,
  input  word_t       OutputPort_i,
  input  word_t       rdat2_i,
  input  word_t       pc4_i,
  input  word_t       lui_imm_i,
  input  regbits_t    wsel_i,
  input  logic        RegWr_i,
  input  logic        halt_i,
  input  logic [2:0]  MemToReg_i,
  input  logic        flush_i,
  input  logic        snoop_inv,
  input  word_t       snoop_addr,
  mem_stage_if.master dc,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic        wb_RegWr,
  output logic        wb_halt,
  output regbits_t    wb_wsel,
  output word_t       wb_wdat
);

  mem_state_t state_q, state_d;

  logic  atomic, link_hit, sc_fail, mem_op;
  logic  ren, wen, stall, done, capture, sc_ok;
  word_t addr, store;
  logic  cur_ren, cur_wen, cur_atomic;
  word_t cur_addr;
  logic  req_ren_q, req_wen_q, req_atomic_q;
  word_t req_addr_q, req_store_q;
  logic  flush_pend_q;
  word_t wdat_d;

  assign atomic  = LLSC_EN & datomic_i;
  assign sc_fail = atomic & dWEN_i & ~link_hit;
  assign mem_op  = valid_i & (dREN_i | dWEN_i) & ~sc_fail;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A failed SC never reaches WAIT, so any atomic store replayed there has already succeeded.
  always_comb begin
    state_d    = state_q;
    ren        = 1'b0;
    wen        = 1'b0;
    addr       = '0;
    store      = '0;
    stall      = 1'b0;
    done       = 1'b0;
    capture    = 1'b0;
    cur_ren    = dREN_i;
    cur_wen    = dWEN_i;
    cur_atomic = atomic;
    cur_addr   = OutputPort_i;
    sc_ok      = ~sc_fail;
    case (state_q)
      IDLE: begin
        ren   = mem_op & dREN_i;
        wen   = mem_op & dWEN_i;
        addr  = OutputPort_i;
        store = rdat2_i;
        if (mem_op && !dc.dhit) begin
          stall   = 1'b1;
          capture = 1'b1;
          state_d = WAIT;
        end else begin
          done = mem_op;
          if (halt_i && valid_i) state_d = HALT;
        end
      end
      WAIT: begin
        ren        = req_ren_q;
        wen        = req_wen_q;
        addr       = req_addr_q;
        store      = req_store_q;
        cur_ren    = req_ren_q;
        cur_wen    = req_wen_q;
        cur_atomic = req_atomic_q;
        cur_addr   = req_addr_q;
        sc_ok      = 1'b1;
        if (dc.dhit) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      HALT: ;
      default: state_d = IDLE;
    endcase
  end

  assign dc.dmemREN   = nRST & ren;
  assign dc.dmemWEN   = nRST & wen;
  assign dc.dmemaddr  = nRST ? addr : '0;
  assign dc.dmemstore = nRST ? store : '0;
  assign mem_stall    = nRST & stall;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      req_ren_q    <= 1'b0;
      req_wen_q    <= 1'b0;
      req_atomic_q <= 1'b0;
      req_addr_q   <= '0;
      req_store_q  <= '0;
    end else if (capture) begin
      req_ren_q    <= dREN_i;
      req_wen_q    <= dWEN_i;
      req_atomic_q <= atomic;
      req_addr_q   <= OutputPort_i;
      req_store_q  <= rdat2_i;
    end
  end

  link_reg u_link (
    .CLK        (CLK),
    .nRST       (nRST),
    .set        (done & cur_ren & cur_atomic),
    .set_addr   (cur_addr),
    .sc_done    (done & cur_wen & cur_atomic),
    .st_done    (done & cur_wen),
    .st_addr    (cur_addr),
    .snoop_inv  (snoop_inv),
    .snoop_addr (snoop_addr),
    .cmp_addr   (OutputPort_i),
    .link_hit   (link_hit)
  );

  always_comb begin
    wdat_d = '0;
    case (memtoreg_t'(MemToReg_i))
      ALU:     wdat_d = OutputPort_i;
      MEM:     wdat_d = dc.dmemload;
      PC4:     wdat_d = pc4_i;
      LUI:     wdat_d = lui_imm_i;
      SC:      wdat_d = {31'd0, sc_ok};
      default: wdat_d = '0;
    endcase
  end

  // A flush seen while stalled is remembered and applied on the first free cycle.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      flush_pend_q <= 1'b0;
      wb_valid     <= 1'b0;
      wb_RegWr     <= 1'b0;
      wb_halt      <= 1'b0;
      wb_wsel      <= '0;
      wb_wdat      <= '0;
    end else begin
      flush_pend_q <= stall ? (flush_pend_q | flush_i) : 1'b0;
      if (state_q == HALT) begin
        wb_halt <= 1'b1;
      end else if (!stall) begin
        if (flush_i || flush_pend_q || !valid_i) begin
          wb_valid <= 1'b0;
          wb_RegWr <= 1'b0;
          wb_halt  <= 1'b0;
          wb_wsel  <= '0;
          wb_wdat  <= '0;
        end else begin
          wb_valid <= 1'b1;
          wb_RegWr <= RegWr_i;
          wb_halt  <= halt_i;
          wb_wsel  <= wsel_i;
          wb_wdat  <= wdat_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed test-plan steps then randomized instruction stream.
module tb_mem_stage;
  import cpu_types_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       valid_i, dREN_i, dWEN_i, datomic_i;
  word_t      OutputPort_i, rdat2_i, pc4_i, lui_imm_i;
  regbits_t   wsel_i;
  logic       RegWr_i, halt_i, flush_i;
  logic [2:0] MemToReg_i;
  logic       snoop_inv;
  word_t      snoop_addr;
  logic       mem_stall, wb_valid, wb_RegWr, wb_halt;
  regbits_t   wb_wsel;
  word_t      wb_wdat;

  mem_stage_if dbus ();

  mem_stage #(.LLSC_EN(1'b1)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .valid_i      (valid_i),
    .dREN_i       (dREN_i),
    .dWEN_i       (dWEN_i),
    .datomic_i    (datomic_i),
    .OutputPort_i (OutputPort_i),
    .rdat2_i      (rdat2_i),
    .pc4_i        (pc4_i),
    .lui_imm_i    (lui_imm_i),
    .wsel_i       (wsel_i),
    .RegWr_i      (RegWr_i),
    .halt_i       (halt_i),
    .MemToReg_i   (MemToReg_i),
    .flush_i      (flush_i),
    .snoop_inv    (snoop_inv),
    .snoop_addr   (snoop_addr),
    .dc           (dbus.master),
    .mem_stall    (mem_stall),
    .wb_valid     (wb_valid),
    .wb_RegWr     (wb_RegWr),
    .wb_halt      (wb_halt),
    .wb_wsel      (wb_wsel),
    .wb_wdat      (wb_wdat)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit       m_lv = 1'b0;
  word_t    m_la = '0;
  bit       e_valid = 1'b0;
  bit       e_rw = 1'b0;
  regbits_t e_ws = '0;
  word_t    e_wd = '0;

  word_t pool [4] = '{32'h200, 32'h204, 32'h300, 32'h1000};

  function automatic bit wmatch(input word_t a, input word_t b);
    return a[31:2] == b[31:2];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One EX/MEM instruction; dcache answers after lat wait cycles; snoop lands on the completion cycle.
  task automatic run_instr(input bit v, input bit r, input bit w, input bit a,
                           input word_t addr, input word_t sdata, input logic [2:0] mtr,
                           input regbits_t ws, input bit rw, input int lat, input bit fl,
                           input word_t ldata, input bit snp, input word_t saddr);
    bit    sc_f, op, sc_succ;
    int    n;
    word_t p4, lui;
    sc_f = a && w && !(m_lv && wmatch(addr, m_la));
    op   = v && (r || w) && !sc_f;
    n    = op ? lat : 0;
    p4   = $urandom;
    lui  = $urandom;
    valid_i = v; dREN_i = r; dWEN_i = w; datomic_i = a;
    OutputPort_i = addr; rdat2_i = sdata; pc4_i = p4; lui_imm_i = lui;
    wsel_i = ws; RegWr_i = rw; MemToReg_i = mtr; halt_i = 1'b0;
    dbus.dmemload = ldata; flush_i = fl; snoop_addr = saddr;
    for (int c = 0; c <= n; c++) begin
      dbus.dhit = (c == n);
      snoop_inv = snp && (c == n);
      @(negedge CLK);
      chk("mem_stall", mem_stall, 32'(c < n));
      chk("dmemREN", dbus.dmemREN, 32'(op && r));
      chk("dmemWEN", dbus.dmemWEN, 32'(op && w));
      if (op) chk("dmemaddr", dbus.dmemaddr, addr);
      if (op && w) chk("dmemstore", dbus.dmemstore, sdata);
      chk("wb_hold_valid", wb_valid, 32'(e_valid));
      if (e_valid) chk("wb_hold_wdat", wb_wdat, e_wd);
      @(posedge CLK);
      #1;
      flush_i = 1'b0;
      snoop_inv = 1'b0;
      dbus.dhit = 1'b0;
    end
    sc_succ = a && w && op;
    if (op && a && r) begin
      m_la = addr;
      m_lv = !(snp && wmatch(saddr, addr));
    end else begin
      if (op && w && wmatch(addr, m_la)) m_lv = 1'b0;
      if (sc_succ) m_lv = 1'b0;
      if (snp && wmatch(saddr, m_la)) m_lv = 1'b0;
    end
    if (!v || fl) begin
      e_valid = 1'b0;
      e_rw    = 1'b0;
    end else begin
      e_valid = 1'b1;
      e_rw    = rw;
      e_ws    = ws;
      case (mtr)
        3'd0:    e_wd = addr;
        3'd1:    e_wd = ldata;
        3'd2:    e_wd = p4;
        3'd3:    e_wd = lui;
        3'd4:    e_wd = {31'd0, !sc_f};
        default: e_wd = 32'd0;
      endcase
    end
    chk("wb_valid", wb_valid, 32'(e_valid));
    chk("wb_RegWr", wb_RegWr, 32'(e_rw));
    chk("wb_halt", wb_halt, 32'd0);
    if (e_valid) begin
      chk("wb_wsel", wb_wsel, 32'(e_ws));
      chk("wb_wdat", wb_wdat, e_wd);
    end
    chk("link_valid", dut.u_link.link_valid, 32'(m_lv));
  endtask

  initial begin
    int    k;
    bit    a, v, rw, fl, snp;
    word_t ad, sa;
    logic [2:0] mtr;

    nRST = 1'b0;
    valid_i = 0; dREN_i = 0; dWEN_i = 0; datomic_i = 0;
    OutputPort_i = '0; rdat2_i = '0; pc4_i = '0; lui_imm_i = '0;
    wsel_i = '0; RegWr_i = 0; halt_i = 0; MemToReg_i = '0; flush_i = 0;
    snoop_inv = 0; snoop_addr = '0; dbus.dhit = 0; dbus.dmemload = '0;
    repeat (3) @(posedge CLK);
    #2;
    chk("rst_stall", mem_stall, 32'd0);
    chk("rst_wb_valid", wb_valid, 32'd0);
    chk("rst_wb_wdat", wb_wdat, 32'd0);
    chk("rst_link", dut.u_link.link_valid, 32'd0);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // LW 0x100, three wait cycles
    run_instr(1, 1, 0, 0, 32'h100, 32'h0, 3'd1, 5'd7, 1, 3, 0, 32'hDEADBEEF, 0, 32'h0);
    chk("lw_wdat", wb_wdat, 32'hDEADBEEF);
    // LL then successful SC
    run_instr(1, 1, 0, 1, 32'h200, 32'h0, 3'd1, 5'd8, 1, 1, 0, 32'h1234, 0, 32'h0);
    run_instr(1, 0, 1, 1, 32'h200, 32'h5, 3'd4, 5'd8, 1, 0, 0, 32'h0, 0, 32'h0);
    chk("sc_ok_wdat", wb_wdat, 32'd1);
    // LL, snoop kill, failing SC
    run_instr(1, 1, 0, 1, 32'h200, 32'h0, 3'd1, 5'd9, 1, 0, 0, 32'h55, 0, 32'h0);
    run_instr(0, 0, 0, 0, 32'h0, 32'h0, 3'd0, 5'd0, 0, 0, 0, 32'h0, 1, 32'h200);
    run_instr(1, 0, 1, 1, 32'h200, 32'h5, 3'd4, 5'd9, 1, 2, 0, 32'h0, 0, 32'h0);
    chk("sc_fail_wdat", wb_wdat, 32'd0);
    // LL racing a snoop: other word keeps the link, same word kills it
    run_instr(1, 1, 0, 1, 32'h200, 32'h0, 3'd1, 5'd3, 1, 0, 0, 32'h1, 1, 32'h204);
    chk("ll_snoop_diff", dut.u_link.link_valid, 32'd1);
    run_instr(1, 1, 0, 1, 32'h200, 32'h0, 3'd1, 5'd3, 1, 1, 0, 32'h2, 1, 32'h202);
    chk("ll_snoop_same", dut.u_link.link_valid, 32'd0);
    // SC whose link is snooped while it waits still commits
    run_instr(1, 1, 0, 1, 32'h300, 32'h0, 3'd1, 5'd4, 1, 0, 0, 32'h3, 0, 32'h0);
    run_instr(1, 0, 1, 1, 32'h301, 32'h77, 3'd4, 5'd4, 1, 2, 0, 32'h0, 1, 32'h300);
    chk("sc_wait_wdat", wb_wdat, 32'd1);
    // flush during a 2-cycle stall
    run_instr(1, 1, 0, 0, 32'h400, 32'h0, 3'd1, 5'd6, 1, 2, 1, 32'hCAFE, 0, 32'h0);
    chk("flush_bubble", wb_valid, 32'd0);

    for (int i = 0; i < 60; i++) begin
      k   = $urandom_range(0, 3);
      a   = ($urandom_range(0, 2) == 0);
      v   = ($urandom_range(0, 9) != 0);
      rw  = $urandom_range(0, 1);
      fl  = ($urandom_range(0, 7) == 0);
      snp = ($urandom_range(0, 3) == 0);
      ad  = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      sa  = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
      mtr = 3'($urandom_range(0, 7));
      if (k == 1) mtr = 3'd1;
      if (k == 2 && a) mtr = 3'd4;
      run_instr(v, k == 1, k == 2, a && (k == 1 || k == 2), ad, $urandom, mtr,
                5'($urandom_range(0, 31)), rw, $urandom_range(0, 3), fl, $urandom, snp, sa);
    end

    // halt, then a store that must not issue, then reset
    valid_i = 1; halt_i = 1; dREN_i = 0; dWEN_i = 0; datomic_i = 0;
    RegWr_i = 0; MemToReg_i = 3'd0; flush_i = 0; dbus.dhit = 0;
    @(posedge CLK);
    #1;
    chk("halt_wb", wb_halt, 32'd1);
    halt_i = 0; dWEN_i = 1; OutputPort_i = 32'h400; rdat2_i = 32'h99; dbus.dhit = 1;
    @(negedge CLK);
    chk("halt_no_wen", dbus.dmemWEN, 32'd0);
    chk("halt_no_stall", mem_stall, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    chk("halt_sticky", wb_halt, 32'd1);
    nRST = 1'b0;
    #1;
    chk("rst2_wen", dbus.dmemWEN, 32'd0);
    chk("rst2_ren", dbus.dmemREN, 32'd0);
    chk("rst2_addr", dbus.dmemaddr, 32'd0);
    chk("rst2_store", dbus.dmemstore, 32'd0);
    chk("rst2_stall", mem_stall, 32'd0);
    chk("rst2_wb_valid", wb_valid, 32'd0);
    chk("rst2_wb_RegWr", wb_RegWr, 32'd0);
    chk("rst2_wb_halt", wb_halt, 32'd0);
    chk("rst2_wb_wsel", wb_wsel, 32'd0);
    chk("rst2_wb_wdat", wb_wdat, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
